// File: rtl/multi_type_shift_pipe_pkg.sv
// multi_type_shift_pipe_pkg: shared mode encoding, stage control flags and level split helper
package multi_type_shift_pipe_pkg;
  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } mode_e;
  typedef struct packed {
    logic fill;
    logic rot;
    logic left;
    logic err;
  } ctl_t;
  // first log level handled by stage k; earlier stages absorb the remainder
  function automatic int lvl_start(int k, int levels, int stages);
    return k * (levels / stages) + (k < levels % stages ? k : levels % stages);
  endfunction
endpackage

// File: rtl/multi_type_shift_stage.sv
// multi_type_shift_stage: register slice applying a group of right shift/rotate levels
module multi_type_shift_stage
  import multi_type_shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BIT_WIDTH = 5,
  parameter int TAG_WIDTH = 4,
  parameter int LVL_LO = 0,
  parameter int LVL_CNT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DATA_WIDTH-1:0]      in_dat,
  input  logic [SHIFT_BIT_WIDTH-1:0] in_amt,
  input  ctl_t                       in_ctl,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_WIDTH-1:0]      out_dat,
  output logic [SHIFT_BIT_WIDTH-1:0] out_amt,
  output ctl_t                       out_ctl,
  output logic [TAG_WIDTH-1:0]       out_tag
);
  logic [DATA_WIDTH-1:0] shifted;
  assign in_rdy = !out_vld || out_rdy;
  always_comb begin
    shifted = in_dat;
    for (int j = LVL_LO; j < LVL_LO + LVL_CNT; j++)
      if (in_amt[j])
        shifted = in_ctl.rot ? (shifted >> (1 << j)) | (shifted << (DATA_WIDTH - (1 << j)))
                             : (shifted >> (1 << j)) | (in_ctl.fill ? ~({DATA_WIDTH{1'b1}} >> (1 << j)) : '0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_amt <= '0;
      out_ctl <= '0;
      out_tag <= '0;
    end else begin
      if (in_rdy) out_vld <= in_vld;
      if (in_rdy && in_vld) begin
        out_dat <= shifted;
        out_amt <= in_amt;
        out_ctl <= in_ctl;
        out_tag <= in_tag;
      end
    end
  end
endmodule

// File: rtl/multi_type_shift_pipe.sv
// multi_type_shift_pipe: pipelined barrel shifter/rotator with valid/ready and a sideband tag
module multi_type_shift_pipe
  import multi_type_shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int SHIFT_BIT_WIDTH = $clog2(DATA_WIDTH),
  parameter int STAGE_NUM = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iVld,
  output logic                       oRdy,
  input  logic [2:0]                 iMode,
  input  logic [DATA_WIDTH-1:0]      iDat,
  input  logic [SHIFT_BIT_WIDTH-1:0] iSftBit,
  input  logic [TAG_WIDTH-1:0]       iTag,
  output logic                       oVld,
  input  logic                       iRdy,
  output logic [DATA_WIDTH-1:0]      oDat,
  output logic [TAG_WIDTH-1:0]       oTag,
  output logic                       oErr
);
  logic [STAGE_NUM:0]         vld, rdy;
  logic [DATA_WIDTH-1:0]      dat [0:STAGE_NUM];
  logic [SHIFT_BIT_WIDTH-1:0] amt [0:STAGE_NUM];
  ctl_t                       ctl [0:STAGE_NUM];
  logic [TAG_WIDTH-1:0]       tag [0:STAGE_NUM];
  logic [DATA_WIDTH-1:0]      rev_in, rev_out;
  logic                       left;
  logic                       unused_bits;
  if ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || DATA_WIDTH < 2 || TAG_WIDTH < 1 ||
      STAGE_NUM < 1 || STAGE_NUM > SHIFT_BIT_WIDTH) begin : g_param_err
`ifdef CHECK_ERR_EXIT
    $fatal(1, "multi_type_shift_pipe: illegal DATA_WIDTH/STAGE_NUM/TAG_WIDTH");
`else
    $error("multi_type_shift_pipe: illegal DATA_WIDTH/STAGE_NUM/TAG_WIDTH");
`endif
  end
  // left operations run through the right-shift datapath on a bit-reversed operand
  assign left = iMode == SLL || iMode == ROL;
  assign rev_in = {<<{iDat}};
  assign vld[0] = iVld;
  assign oRdy = rdy[0];
  assign dat[0] = left ? rev_in : iDat;
  assign amt[0] = iSftBit;
  assign ctl[0] = '{fill: iMode == SRA && iDat[DATA_WIDTH-1], rot: iMode == ROL || iMode == ROR,
                    left: left, err: iMode > 3'd4};
  assign tag[0] = iTag;
  assign rdy[STAGE_NUM] = iRdy;
  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stage
    localparam int LO = lvl_start(k, SHIFT_BIT_WIDTH, STAGE_NUM);
    multi_type_shift_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .SHIFT_BIT_WIDTH(SHIFT_BIT_WIDTH),
      .TAG_WIDTH(TAG_WIDTH),
      .LVL_LO(LO),
      .LVL_CNT(lvl_start(k + 1, SHIFT_BIT_WIDTH, STAGE_NUM) - LO)
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_vld(vld[k]),
      .in_rdy(rdy[k]),
      .in_dat(dat[k]),
      .in_amt(amt[k]),
      .in_ctl(ctl[k]),
      .in_tag(tag[k]),
      .out_vld(vld[k+1]),
      .out_rdy(rdy[k+1]),
      .out_dat(dat[k+1]),
      .out_amt(amt[k+1]),
      .out_ctl(ctl[k+1]),
      .out_tag(tag[k+1])
    );
  end
  assign rev_out = {<<{dat[STAGE_NUM]}};
  assign oVld = vld[STAGE_NUM];
  assign oTag = tag[STAGE_NUM];
  assign oErr = ctl[STAGE_NUM].err;
  assign oDat = ctl[STAGE_NUM].err ? '0 : ctl[STAGE_NUM].left ? rev_out : dat[STAGE_NUM];
  assign unused_bits = ^{amt[STAGE_NUM], ctl[STAGE_NUM].fill, ctl[STAGE_NUM].rot};
endmodule
